// File: rtl/nf_bus_pkg.sv
// nf_bus_pkg: shared types for the nanoFOX bus initiator
package nf_bus_pkg;
  localparam int WAIT_W = 4;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } nf_bus_cmd_t;
  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} nf_bus_init_st_t;
endpackage

// File: rtl/nf_bus_init_if.sv
// nf_bus_init_if: command, response and peripheral-bus signals of the initiator
interface nf_bus_init_if;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wd;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rd;
  logic [31:0] addr, wd, rd;
  logic        we, busy;
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wd, rsp_ready, rd,
    output cmd_ready, rsp_valid, rsp_we, rsp_rd, addr, we, wd, busy
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wd, rsp_ready, rd,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rd, addr, we, wd, busy
  );
endinterface

// File: rtl/nf_bus_init_fifo.sv
// nf_cmd_fifo: synchronous command FIFO with registered occupancy count
module nf_cmd_fifo import nf_bus_pkg::*; #(
  parameter int DEPTH = 4
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  nf_bus_cmd_t wdat,
  output nf_bus_cmd_t rdat,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  nf_bus_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign rdat = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdat;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/nf_bus_init.sv
// nf_bus_init: command-FIFO driven initiator for the nanoFOX simple peripheral bus
module nf_bus_init import nf_bus_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_CYC = 0
)(
  input logic           clk,
  input logic           reset,
  nf_bus_init_if.master io
);
  nf_bus_init_st_t st, nst;
  nf_bus_cmd_t in_cmd, head, cmd;
  logic [WAIT_W-1:0] cnt;
  logic full, empty, pop, load, cap, ack, done;
  assign in_cmd = {io.cmd_we, io.cmd_addr, io.cmd_wd};
  assign io.cmd_ready = !full;
  assign io.busy = st != IDLE || !empty;
  assign done = cnt == WAIT_W'(WAIT_CYC);
  nf_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (io.cmd_valid),
    .pop   (pop),
    .wdat  (in_cmd),
    .rdat  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk)
    st <= reset ? IDLE : nst;
  always_comb
    nst = st == IDLE   ? (empty ? IDLE : LOAD) :
          st == LOAD   ? ACCESS :
          st == ACCESS ? (done ? RESP : ACCESS) :
                         (io.rsp_ready ? IDLE : RESP);
  always_comb begin
    pop = st == IDLE && !empty;
    load = st == LOAD;
    cap = st == ACCESS && done;
    ack = st == RESP && io.rsp_ready;
  end
  // we drops after the first ACCESS cycle so every write is a one-cycle strobe
  always_ff @(posedge clk)
    if (reset) begin
      cmd <= '0;
      cnt <= '0;
      io.addr <= '0;
      io.wd <= '0;
      io.we <= 1'b0;
      io.rsp_valid <= 1'b0;
      io.rsp_we <= 1'b0;
      io.rsp_rd <= '0;
    end else begin
      if (pop) cmd <= head;
      if (load) begin
        io.addr <= cmd.addr;
        io.wd <= cmd.we ? cmd.wd : '0;
        io.we <= cmd.we;
        cnt <= '0;
      end
      if (st == ACCESS) begin
        io.we <= 1'b0;
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        io.rsp_rd <= cmd.we ? '0 : io.rd;
        io.rsp_we <= cmd.we;
        io.rsp_valid <= 1'b1;
        io.addr <= '0;
        io.wd <= '0;
      end
      if (ack) io.rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_nf_bus_init.sv
// tb_nf_bus_init: directed scoreboard bench for nf_bus_init with a small GPIO responder
module tb_nf_bus_init;
  localparam logic [31:0] GPI = 32'h100, GPO = 32'h104, DIR = 32'h108;
  logic clk = 0, reset = 1, rnd_en = 0;
  int checks = 0, errors = 0;
  logic [32:0] q0[$], q3[$];
  logic [7:0] gpi0 = 8'h5A, gpi3 = 8'h3C, gpo0 = 0, dir0 = 0;
  logic st0 = 0;
  logic [32:0] pv0 = 0;
  int wn, wc, an, ac, rc;
  logic [31:0] wdv;
  nf_bus_init_if i0();
  nf_bus_init_if i3();
  nf_bus_init #(.FIFO_DEPTH(4), .WAIT_CYC(0)) d0 (.clk(clk), .reset(reset), .io(i0));
  nf_bus_init #(.FIFO_DEPTH(4), .WAIT_CYC(3)) d3 (.clk(clk), .reset(reset), .io(i3));
  always #5 clk = ~clk;
  // GPIO-like responders: GPI/GPO/DIR registers, 8 bits wide
  assign i0.rd = i0.addr == GPI ? {24'h0, gpi0} : i0.addr == GPO ? {24'h0, gpo0} :
                 i0.addr == DIR ? {24'h0, dir0} : 32'h0;
  assign i3.rd = i3.addr == GPI ? {24'h0, gpi3} : 32'h0;
  always @(posedge clk)
    if (i0.we) begin
      if (i0.addr == GPO) gpo0 <= i0.wd[7:0];
      if (i0.addr == DIR) dir0 <= i0.wd[7:0];
    end
  always @(posedge clk) begin
    #2;
    if (rnd_en) i0.rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string n, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && i0.rsp_valid) begin
      if (st0) chk("rsp0_stall_hold", {i0.rsp_we, i0.rsp_rd}, pv0);
      if (i0.rsp_ready) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp0_extra: got %h expected no response", {i0.rsp_we, i0.rsp_rd});
        end else chk("rsp0", {i0.rsp_we, i0.rsp_rd}, q0.pop_front());
        st0 <= 1'b0;
      end else begin
        st0 <= 1'b1;
        pv0 <= {i0.rsp_we, i0.rsp_rd};
      end
    end else st0 <= 1'b0;
    if (!reset && i3.rsp_valid && i3.rsp_ready) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp3_extra: got %h expected no response", {i3.rsp_we, i3.rsp_rd});
      end else chk("rsp3", {i3.rsp_we, i3.rsp_rd}, q3.pop_front());
    end
  end

  task automatic push(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e);
    logic r;
    if (s) begin
      i3.cmd_we = w; i3.cmd_addr = a; i3.cmd_wd = d; i3.cmd_valid = 1;
    end else begin
      i0.cmd_we = w; i0.cmd_addr = a; i0.cmd_wd = d; i0.cmd_valid = 1;
    end
    r = s ? i3.cmd_ready : i0.cmd_ready;
    for (int t = 0; t < 100 && !r; t++) begin
      @(posedge clk); #1;
      r = s ? i3.cmd_ready : i0.cmd_ready;
    end
    chk("cmd_accept", r, 1);
    if (r) begin
      @(posedge clk); #1;
      if (s) q3.push_back({w, e}); else q0.push_back({w, e});
    end
    i0.cmd_valid = 0;
    i3.cmd_valid = 0;
  endtask

  // cycle numbers count the cycle after the acceptance edge as 1
  task automatic measure(input bit s, input logic [31:0] a, output int we_n, output int we_c,
                         output int a_n, output int a_c, output int rv_c, output logic [31:0] wdx);
    we_n = 0; we_c = 0; a_n = 0; a_c = 0; rv_c = 0; wdx = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (s ? i3.we : i0.we) begin
        we_n++;
        if (we_c == 0) we_c = k + 1;
        wdx = s ? i3.wd : i0.wd;
      end
      if ((s ? i3.addr : i0.addr) == a) begin
        a_n++;
        if (a_c == 0) a_c = k + 1;
      end
      if ((s ? i3.rsp_valid : i0.rsp_valid) && rv_c == 0) rv_c = k + 1;
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && (i0.busy || i3.busy); t++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", {i0.busy, i3.busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    i0.cmd_valid = 0; i0.cmd_we = 0; i0.cmd_addr = 0; i0.cmd_wd = 0; i0.rsp_ready = 1;
    i3.cmd_valid = 0; i3.cmd_we = 0; i3.cmd_addr = 0; i3.cmd_wd = 0; i3.rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_cmd_ready", i0.cmd_ready, 1);
    chk("rst_rsp_valid", i0.rsp_valid, 0);
    chk("rst_rsp_we", i0.rsp_we, 0);
    chk("rst_rsp_rd", i0.rsp_rd, 0);
    chk("rst_addr", i0.addr, 0);
    chk("rst_we", i0.we, 0);
    chk("rst_wd", i0.wd, 0);
    chk("rst_busy", {i0.busy, i3.busy}, 0);
    // write GPO then read it back, WAIT_CYC=0
    push(0, 1, GPO, 32'hA5, 0);
    measure(0, GPO, wn, wc, an, ac, rc, wdv);
    chk("wr_we_count", wn, 1);
    chk("wr_we_cycle", wc, 3);
    chk("wr_wd", wdv, 32'hA5);
    chk("wr_addr_cycles", an, 1);
    chk("wr_rsp_cycle", rc, 4);
    push(0, 0, GPO, 0, 32'hA5);
    measure(0, GPO, wn, wc, an, ac, rc, wdv);
    chk("rd_we_count", wn, 0);
    chk("rd_addr_cycle", ac, 3);
    chk("rd_rsp_cycle", rc, 4);
    // read GPI with WAIT_CYC=3
    push(1, 0, GPI, 0, 32'h3C);
    measure(1, GPI, wn, wc, an, ac, rc, wdv);
    chk("w3_addr_cycles", an, 4);
    chk("w3_addr_first", ac, 3);
    chk("w3_rsp_cycle", rc, 7);
    wait_idle();
    // back-to-back with response stalled: FIFO fills after five accepts
    i0.rsp_ready = 0;
    push(0, 1, GPO, 32'h11, 0);
    push(0, 0, GPO, 0, 32'h11);
    push(0, 1, DIR, 32'h22, 0);
    push(0, 0, DIR, 0, 32'h22);
    push(0, 0, GPI, 0, 32'h5A);
    chk("full_ready", i0.cmd_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("full_ready_hold", i0.cmd_ready, 0);
    chk("full_busy", i0.busy, 1);
    chk("full_rsp_valid", i0.rsp_valid, 1);
    i0.rsp_ready = 1;
    push(0, 1, GPO, 32'h66, 0);
    wait_idle();
    chk("b2b_drained", q0.size(), 0);
    // simultaneous push and pop with three entries queued
    i0.rsp_ready = 0;
    push(0, 1, GPO, 32'h44, 0);
    push(0, 0, GPO, 0, 32'h44);
    push(0, 0, DIR, 0, 32'h22);
    push(0, 0, GPI, 0, 32'h5A);
    for (int t = 0; t < 50 && !i0.rsp_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("c3_count", d0.u_fifo.cnt, 3);
    i0.rsp_ready = 1;
    @(posedge clk); #1;
    chk("c3_count_idle", d0.u_fifo.cnt, 3);
    i0.cmd_valid = 1; i0.cmd_we = 0; i0.cmd_addr = GPO; i0.cmd_wd = 0;
    @(posedge clk); #1;
    i0.cmd_valid = 0;
    q0.push_back({1'b0, 32'h44});
    chk("c3_count_pushpop", d0.u_fifo.cnt, 3);
    chk("c3_ready", i0.cmd_ready, 1);
    wait_idle();
    chk("c3_drained", q0.size(), 0);
    // random response back-pressure
    rnd_en = 1;
    push(0, 1, DIR, 32'hFF, 0);
    push(0, 0, DIR, 0, 32'hFF);
    wait_idle();
    rnd_en = 0;
    i0.rsp_ready = 1;
    chk("rnd_drained", q0.size(), 0);
    // reset during ACCESS of a write with two commands queued
    push(0, 1, GPO, 32'h77, 0);
    push(0, 1, GPO, 32'h78, 0);
    push(0, 0, GPO, 0, 32'h78);
    chk("mid_we_high", i0.we, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    q0.delete();
    chk("mid_rst_we", i0.we, 0);
    chk("mid_rst_rsp_valid", i0.rsp_valid, 0);
    chk("mid_rst_busy", i0.busy, 0);
    chk("mid_rst_ready", i0.cmd_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_quiet", {i0.busy, i0.rsp_valid}, 0);
    push(0, 1, GPO, 32'h5C, 0);
    measure(0, GPO, wn, wc, an, ac, rc, wdv);
    chk("post_we_count", wn, 1);
    chk("post_we_cycle", wc, 3);
    chk("post_wd", wdv, 32'h5C);
    chk("post_rsp_cycle", rc, 4);
    push(0, 0, GPO, 0, 32'h5C);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("end_q0", q0.size(), 0);
    chk("end_q3", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
